// File: rtl/meta_rr_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meta_rr_arbiter_pkg : queue-manager constants and metadata type  (rev 1.0)
// ----------------------------------------------------------------------------
package meta_rr_arbiter_pkg;

  localparam int NB_PKT_QUEUE_MANAGERS = 4;
  localparam int PKT_QM_ID_WIDTH       = $clog2(NB_PKT_QUEUE_MANAGERS);

  typedef struct packed {
    logic [PKT_QM_ID_WIDTH-1:0] qm_id;
    logic [11:0]                queue_id;
    logic [15:0]                pkt_len;
    logic [1:0]                 flags;
  } pkt_meta_with_queues_t;

  localparam int META_DWIDTH = $bits(pkt_meta_with_queues_t);

  // Index width for n requesters, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meta_rr_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meta_rr_arbiter_if : requester/downstream handshake bundle  (rev 1.0)
// ----------------------------------------------------------------------------
interface meta_rr_arbiter_if
  import meta_rr_arbiter_pkg::*;
#(
  parameter int NB_INPUTS = NB_PKT_QUEUE_MANAGERS,
  parameter int DWIDTH    = META_DWIDTH
);

  localparam int c_CHW = ch_width(NB_INPUTS);

  logic [NB_INPUTS-1:0][DWIDTH-1:0] in_data;
  logic [NB_INPUTS-1:0]             in_valid;
  logic [NB_INPUTS-1:0]             in_ready;
  logic [DWIDTH-1:0]                out_data;
  logic [c_CHW-1:0]                 out_channel;
  logic                             out_valid;
  logic                             out_ready;
  logic [31:0]                      stall_cnt;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_channel, out_valid, stall_cnt
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_channel, out_valid, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/meta_skid_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meta_skid_fifo : 2-entry head/tail buffer, output driven from head register (rev 1.0)
// ----------------------------------------------------------------------------
module meta_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic      [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;

  // The producer never pushes when full, so a push in the two-entry state is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({i_push, i_pop})
            2'b11: r_head <= i_data;
            2'b10: begin
              r_tail  <= i_data;
              r_count <= 2'd2;
            end
            2'b01: r_count <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          if (i_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/meta_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meta_rr_arbiter : round-robin arbiter of queue-manager metadata  (rev 1.0)
// ----------------------------------------------------------------------------
module meta_rr_arbiter
  import meta_rr_arbiter_pkg::*;
#(
  parameter int NB_INPUTS = NB_PKT_QUEUE_MANAGERS,
  parameter int DWIDTH    = META_DWIDTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  meta_rr_arbiter_if.slave bus
);

  localparam int c_CHW = ch_width(NB_INPUTS);
  localparam int c_FW  = DWIDTH + c_CHW;

  logic [c_CHW-1:0]     r_rr_ptr;
  logic [c_CHW-1:0]     w_cand;
  logic [c_CHW-1:0]     w_gnt_idx;
  logic                 w_gnt_vld;
  logic                 w_push;
  logic                 w_pop;
  logic [NB_INPUTS-1:0] w_in_ready;
  logic [1:0]           w_occ;
  logic [c_FW-1:0]      w_fifo_dout;
  logic                 w_fifo_vld;
  logic [31:0]          r_stall_cnt;

  // Scan from the far end back so the candidate nearest r_rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NB_INPUTS - 1; k >= 0; k--) begin
      w_cand = r_rr_ptr + c_CHW'(k);
      if (bus.in_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Acceptance looks only at registered occupancy, keeping out_ready off the in_ready path.
  assign w_push = w_gnt_vld && (w_occ < 2'd2) && !rst;

  always_comb begin
    w_in_ready = '0;
    if (w_push) begin
      w_in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= w_gnt_idx + c_CHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((|bus.in_valid) && !w_push && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  meta_skid_fifo #(
    .WIDTH (c_FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_gnt_idx, bus.in_data[w_gnt_idx]}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_vld),
    .o_count (w_occ)
  );

  assign w_pop = bus.out_valid && bus.out_ready;

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_fifo_vld && !rst;
  assign bus.out_data    = rst ? '0 : w_fifo_dout[DWIDTH-1:0];
  assign bus.out_channel = rst ? '0 : w_fifo_dout[c_FW-1:DWIDTH];
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
